// File: rtl/count_pkg.sv
// Shared state encodings for the count sequencer and its prescaler.
package count_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a step rate; TC flags the wrap cycle while enabled.
module tick_prescaler #(
  parameter int unsigned DIV_MODULO = 12500000,
  parameter int unsigned DIV_WIDTH  = 24
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TC
);

  localparam logic [DIV_WIDTH-1:0] LAST_CNT = DIV_WIDTH'(DIV_MODULO - 1);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign TC = EN && (cnt_q == LAST_CNT);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      cnt_q <= '0;
    end else if (EN) begin
      cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run-control FSM and up/down digit counter stepped by the tick prescaler.
module count_sequencer
  import count_pkg::*;
#(
  parameter int unsigned DIV_MODULO   = 12500000,
  parameter int unsigned DIV_WIDTH    = 24,
  parameter int unsigned DIGIT_MODULO = 10,
  parameter int unsigned WIDTH        = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic               CLEAR,
  input  logic               UP,
  input  logic [WIDTH-1:0]   LIMIT,
  input  logic               AUTO_RELOAD,
  output logic [WIDTH-1:0]   COUNT,
  output logic               TICK,
  output logic               DONE,
  output logic               RUNNING,
  output logic [STATE_W-1:0] STATE
);

  localparam logic [WIDTH-1:0] MAX_DIGIT = WIDTH'(DIGIT_MODULO - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             running_q;

  logic             presc_en, presc_clr, presc_tc;
  logic [WIDTH-1:0] limit_clamped, end_val, start_val, next_val;

  // STOP and CLEAR pre-empt the prescaler on the edge they are sampled.
  assign presc_en = (state_q == ST_RUN) && !CLEAR && !STOP;

  tick_prescaler #(
    .DIV_MODULO(DIV_MODULO),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .CLK(CLK),
    .RST(RST),
    .EN (presc_en),
    .CLR(presc_clr),
    .TC (presc_tc)
  );

  assign limit_clamped = (32'(LIMIT) >= DIGIT_MODULO) ? MAX_DIGIT : LIMIT;
  assign end_val       = dir_q ? limit_q : '0;
  assign start_val     = dir_q ? '0 : limit_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    next_val  = (count_q == end_val) ? start_val :
                dir_q ? count_q + 1'b1 : count_q - 1'b1;

    if (CLEAR) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      presc_clr = 1'b1;
    end else if (STOP) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (START && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      dir_d     = UP;
      limit_d   = limit_clamped;
      count_d   = UP ? '0 : limit_clamped;
      presc_clr = 1'b1;
      state_d   = ST_RUN;
    end else if (START && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end else if (presc_tc) begin
      tick_d  = 1'b1;
      count_d = next_val;
      if (next_val == end_val) begin
        done_d = 1'b1;
        if (!AUTO_RELOAD) state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      limit_q   <= MAX_DIGIT;
      dir_q     <= 1'b1;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign COUNT   = count_q;
  assign TICK    = tick_q;
  assign DONE    = done_q;
  assign RUNNING = running_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with a short prescaler (DIV_MODULO=4).
module tb_count_sequencer;

  localparam int unsigned DIV = 4;

  logic       CLK = 1'b0;
  logic       RST, START, STOP, CLEAR, UP, AUTO_RELOAD;
  logic [3:0] LIMIT;
  logic [3:0] COUNT;
  logic       TICK, DONE, RUNNING;
  logic [1:0] STATE;

  count_sequencer #(
    .DIV_MODULO  (DIV),
    .DIV_WIDTH   (3),
    .DIGIT_MODULO(10),
    .WIDTH       (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .STOP       (STOP),
    .CLEAR      (CLEAR),
    .UP         (UP),
    .LIMIT      (LIMIT),
    .AUTO_RELOAD(AUTO_RELOAD),
    .COUNT      (COUNT),
    .TICK       (TICK),
    .DONE       (DONE),
    .RUNNING    (RUNNING),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int unsigned edge_no;
    logic [3:0]  cnt;
    logic        done;
    logic [1:0]  st;
  } exp_t;

  exp_t        sbq[$];
  int unsigned ecount = 0;
  int unsigned last_edge = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;

  always @(posedge CLK) ecount <= ecount + 1;

  // Monitor: every visible TICK is matched against the next expected step.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (TICK === 1'b1) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_tick: edge=%0d count=%0d, required no tick", ecount, COUNT);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (ecount != e.edge_no || COUNT !== e.cnt || DONE !== e.done || STATE !== e.st) begin
            mismatched++;
            $display("FAIL tick: got edge=%0d count=%0d done=%0b state=%0d, required edge=%0d count=%0d done=%0b state=%0d",
                     ecount, COUNT, DONE, STATE, e.edge_no, e.cnt, e.done, e.st);
          end
        end
      end else if (DONE === 1'b1) begin
        compared++;
        mismatched++;
        $display("FAIL done_without_tick: edge=%0d done=1, required 0", ecount);
      end
    end
  end

  task automatic push(input int unsigned e, input int unsigned c, input logic d,
                      input logic [1:0] s);
    exp_t x;
    x.edge_no = e;
    x.cnt     = 4'(c);
    x.done    = d;
    x.st      = s;
    sbq.push_back(x);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic req(input logic s, input logic p, input logic c);
    START = s;
    STOP  = p;
    CLEAR = c;
    @(posedge CLK);
    #1;
    START = 1'b0;
    STOP  = 1'b0;
    CLEAR = 1'b0;
    last_edge = ecount;
  endtask

  task automatic wait_to(input int unsigned e);
    while (ecount < e) begin
      @(posedge CLK);
      #1;
    end
  endtask

  int unsigned e0;

  initial begin
    RST = 1'b1; START = 1'b1; STOP = 1'b0; CLEAR = 1'b0;
    UP = 1'b1; LIMIT = 4'd0; AUTO_RELOAD = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; START = 1'b0;
    chk("reset_count", COUNT, 0);
    chk("reset_state", STATE, 0);
    chk("reset_flags", {TICK, DONE, RUNNING}, 0);

    // Up, no reload, limit 3.
    UP = 1'b1; LIMIT = 4'd3; AUTO_RELOAD = 1'b0;
    req(1, 0, 0); e0 = last_edge;
    chk("up_start_state", STATE, 1);
    chk("up_start_running", RUNNING, 1);
    push(e0 + 4, 1, 0, 2'b01);
    push(e0 + 8, 2, 0, 2'b01);
    push(e0 + 12, 3, 1, 2'b11);
    wait_to(e0 + 16);
    chk("up_done_state", STATE, 3);
    chk("up_done_count", COUNT, 3);
    chk("up_done_running", RUNNING, 0);

    // Down with reload, limit 2; live UP/LIMIT changes must be ignored.
    UP = 1'b0; LIMIT = 4'd2; AUTO_RELOAD = 1'b1;
    req(1, 0, 0); e0 = last_edge;
    UP = 1'b1; LIMIT = 4'd7;
    chk("down_start_count", COUNT, 2);
    push(e0 + 4, 1, 0, 2'b01);
    push(e0 + 8, 0, 1, 2'b01);
    push(e0 + 12, 2, 0, 2'b01);
    push(e0 + 16, 1, 0, 2'b01);
    push(e0 + 20, 0, 1, 2'b01);
    wait_to(e0 + 21);
    chk("down_reload_state", STATE, 1);
    req(0, 0, 1);
    chk("clear_state", STATE, 0);
    chk("clear_count", COUNT, 0);

    // LIMIT=0 up, no reload: DONE on the first step.
    UP = 1'b1; LIMIT = 4'd0; AUTO_RELOAD = 1'b0;
    req(1, 0, 0); e0 = last_edge;
    push(e0 + 4, 0, 1, 2'b11);
    wait_to(e0 + 6);
    chk("lim0_state", STATE, 3);

    // Pause with prescaler at 2, resume 5 cycles later.
    LIMIT = 4'd9;
    req(1, 0, 0); e0 = last_edge;
    wait_to(e0 + 2);
    req(0, 1, 0);
    chk("pause_state", STATE, 2);
    chk("pause_running", RUNNING, 0);
    wait_to(e0 + 7);
    chk("pause_frozen_count", COUNT, 0);
    req(1, 0, 0);
    chk("resume_state", STATE, 1);
    push(e0 + 10, 1, 0, 2'b01);
    push(e0 + 14, 2, 0, 2'b01);
    wait_to(e0 + 14);
    chk("resume_count", COUNT, 2);
    req(0, 0, 1);

    // Clamp: LIMIT=12 behaves as 9.
    LIMIT = 4'd12;
    req(1, 0, 0); e0 = last_edge;
    for (int k = 1; k <= 9; k++) begin
      push(e0 + 4 * k, k, k == 9, (k == 9) ? 2'b11 : 2'b01);
    end
    wait_to(e0 + 40);
    chk("clamp_state", STATE, 3);
    chk("clamp_count", COUNT, 9);

    // STOP+START together -> PAUSE; CLEAR+STOP together -> IDLE.
    LIMIT = 4'd5;
    req(1, 0, 0); e0 = last_edge;
    push(e0 + 4, 1, 0, 2'b01);
    wait_to(e0 + 5);
    req(1, 1, 0);
    chk("stop_start_state", STATE, 2);
    chk("stop_start_count", COUNT, 1);
    req(1, 0, 0);
    req(0, 1, 1);
    chk("clear_stop_state", STATE, 0);
    chk("clear_stop_count", COUNT, 0);

    // STOP on the step edge suppresses the step; resume steps next edge.
    LIMIT = 4'd9; AUTO_RELOAD = 1'b1;
    req(1, 0, 0); e0 = last_edge;
    wait_to(e0 + 3);
    req(0, 1, 0);
    chk("stop_step_state", STATE, 2);
    chk("stop_step_count", COUNT, 0);
    chk("stop_step_tick", TICK, 0);
    req(1, 0, 0);
    push(e0 + 6, 1, 0, 2'b01);
    wait_to(e0 + 7);
    chk("stop_step_resume_count", COUNT, 1);
    req(0, 0, 1);

    wait_to(ecount + 6);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
